mc_controller: RTL

Multicycle successor to the single-cycle ARM-subset controller. A Moore FSM sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction. Condition logic uses the full 4-bit cond field against a registered NZCV flag file. A parameter selects an extended ALU op set, and a second parameter enables the load/store U bit. The block drives the shared-memory multicycle datapath: PC, IR, register file, ALU and result muxes.

---
 rtl/mc_controller_if.sv | 36 +++
 rtl/mc_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
interface mc_controller_if #(
  parameter int unsigned ACW = 2
);

  logic [19:0]    Instr;
  logic [3:0]     ALUFlags;
  logic           PCWrite;
  logic           AdrSrc;
  logic           MemWrite;
  logic           IRWrite;
  logic [1:0]     ResultSrc;
  logic [ACW-1:0] ALUControl;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ImmSrc;
  logic [1:0]     RegSrc;
  logic           RegWrite;
  logic           Undef;
  logic [3:0]     State;

  // Controller side
  modport master (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, Undef, State
  );

  // Datapath side
  modport slave (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, Undef, State
  );

endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: Moore FSM, NZCV flag file and condition check.
module mc_controller #(
  parameter bit EXT_OPS = 1'b0,
  parameter bit UBIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  mc_controller_if.master   bus
);

  localparam int unsigned ACW = EXT_OPS ? 3 : 2;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;

  logic [3:0] cond;
  logic [1:0] op;
  logic       i_bit, s_bit, l_bit, u_bit;
  logic [3:0] cmd, rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign i_bit     = bus.Instr[13];
  assign cmd       = bus.Instr[12:9];
  assign s_bit     = bus.Instr[8];
  assign l_bit     = bus.Instr[8];
  assign u_bit     = bus.Instr[11];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  // Data-processing command decode
  logic       dp_ok, dp_nowrite, dp_arith, dp_cmp;
  logic [2:0] dp_op;
  logic [1:0] dp_flag_w;
  always_comb begin
    dp_ok      = 1'b1;
    dp_op      = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_arith   = 1'b0;
    dp_cmp     = 1'b0;
    case (cmd)
      4'b0100: dp_arith = 1'b1;
      4'b0010: begin dp_op = ALU_SUB; dp_arith = 1'b1; end
      4'b0000: dp_op = ALU_AND;
      4'b1100: dp_op = ALU_ORR;
      4'b0001: begin
        if (EXT_OPS) dp_op = ALU_EOR;
        else         dp_ok = 1'b0;
      end
      4'b1010: begin
        if (EXT_OPS) begin
          dp_op      = ALU_SUB;
          dp_arith   = 1'b1;
          dp_nowrite = 1'b1;
          dp_cmp     = 1'b1;
        end else begin
          dp_ok = 1'b0;
        end
      end
      default: dp_ok = 1'b0;
    endcase
    // Compares always update flags; unsupported commands never do
    dp_flag_w = dp_ok ? {s_bit | dp_cmp, (s_bit | dp_cmp) & dp_arith} : 2'b00;
  end

  // Condition check against the registered flags
  logic n_f, z_f, c_f, v_f, cond_ex;
  assign {n_f, z_f, c_f, v_f} = flags_q;
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = z_f;
      4'h1: cond_ex = ~z_f;
      4'h2: cond_ex = c_f;
      4'h3: cond_ex = ~c_f;
      4'h4: cond_ex = n_f;
      4'h5: cond_ex = ~n_f;
      4'h6: cond_ex = v_f;
      4'h7: cond_ex = ~v_f;
      4'h8: cond_ex = c_f & ~z_f;
      4'h9: cond_ex = ~c_f | z_f;
      4'hA: cond_ex = (n_f == v_f);
      4'hB: cond_ex = (n_f != v_f);
      4'hC: cond_ex = ~z_f & (n_f == v_f);
      4'hD: cond_ex = z_f | (n_f != v_f);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore control outputs
  logic       next_pc, branch, reg_w, mem_w, ir_write, adr_src, src_a, undef;
  logic [1:0] result_src, src_b, flag_w;
  logic [2:0] alu_op;
  always_comb begin
    state_d    = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    src_a      = 1'b0;
    undef      = 1'b0;
    result_src = 2'b00;
    src_b      = 2'b00;
    flag_w     = 2'b00;
    alu_op     = ALU_ADD;
    case (state_q)
      FETCH: begin
        ir_write   = 1'b1;
        src_a      = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        next_pc    = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        src_a      = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = i_bit ? EXECI : EXECR;
          2'b10:   state_d = BRANCH;
          default: begin state_d = FETCH; undef = 1'b1; end
        endcase
        if (op == 2'b00 && !dp_ok) undef = 1'b1;
      end
      MEMADR: begin
        src_b   = 2'b01;
        alu_op  = (UBIT_EN && !u_bit) ? ALU_SUB : ALU_ADD;
        state_d = l_bit ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = FETCH;
      end
      EXECR, EXECI: begin
        src_b   = (state_q == EXECI) ? 2'b01 : 2'b00;
        alu_op  = dp_op;
        flag_w  = dp_flag_w;
        state_d = ALUWB;
      end
      ALUWB: begin
        reg_w   = dp_ok & ~dp_nowrite;
        state_d = FETCH;
      end
      BRANCH: begin
        src_b      = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // NZCV flag file, written at the edge that ends EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (flag_w[1] && cond_ex) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0] && cond_ex) flags_q[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Condition-gated writes; enables held low during reset
  logic pcs;
  assign pcs            = branch | ((rd == 4'd15) & reg_w);
  assign bus.PCWrite    = reset & (next_pc | (pcs & cond_ex));
  assign bus.RegWrite   = reset & reg_w & cond_ex;
  assign bus.MemWrite   = reset & mem_w & cond_ex;
  assign bus.IRWrite    = reset & ir_write;
  assign bus.Undef      = reset & undef;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = ACW'(alu_op);
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
  assign bus.State      = state_q;

endmodule
